// File: rtl/ai_mem_arbiter_if.sv
// Bundle of every signal between the AI memory arbiter, its requester slots and the shared memory port.
// Latency: none. This file holds wiring only.
// Backpressure: req_i stays high until ready_o or err_o. mem_ready stalls the granted slot.
// Ports: requester side req/lock/we/addr/wdata/wmask in, ready/err/rdata/grant out;
//        memory side mem_req/we/addr/wdata/wmask out, mem_rdata/mem_ready in; timeout_flag out.
// The slave modport is the arbiter's view. The master modport is the view of the
// surrounding engines and memory.
interface ai_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 64
);
  logic [NUM_REQ-1:0]      req_i;
  logic [NUM_REQ-1:0]      lock_i;
  logic [NUM_REQ-1:0]      we_i;
  logic [NUM_REQ*XLEN-1:0] addr_i;
  logic [NUM_REQ*XLEN-1:0] wdata_i;
  logic [NUM_REQ*8-1:0]    wmask_i;
  logic [NUM_REQ-1:0]      ready_o;
  logic [NUM_REQ-1:0]      err_o;
  logic [XLEN-1:0]         rdata_o;
  logic [NUM_REQ-1:0]      grant_o;
  logic                    mem_req;
  logic                    mem_we;
  logic [XLEN-1:0]         mem_addr;
  logic [XLEN-1:0]         mem_wdata;
  logic [7:0]              mem_wmask;
  logic [XLEN-1:0]         mem_rdata;
  logic                    mem_ready;
  logic                    timeout_flag;

  modport slave (
    input  req_i, lock_i, we_i, addr_i, wdata_i, wmask_i, mem_rdata, mem_ready,
    output ready_o, err_o, rdata_o, grant_o, mem_req, mem_we, mem_addr,
           mem_wdata, mem_wmask, timeout_flag
  );

  modport master (
    output req_i, lock_i, we_i, addr_i, wdata_i, wmask_i, mem_rdata, mem_ready,
    input  ready_o, err_o, rdata_o, grant_o, mem_req, mem_we, mem_addr,
           mem_wdata, mem_wmask, timeout_flag
  );
endinterface

// File: rtl/ai_mem_arbiter.sv
// Round-robin arbiter of the shared AI memory port for matmul/conv2d/pooling/batchnorm.
// Latency: 1 cycle from request to mem_req. ready_o/err_o pulse 1 cycle after mem_ready/timeout.
// Backpressure: the grant holds while mem_ready is low, bounded by TIMEOUT wait cycles.
// Ports: clk and rst (async, active-high) are plain ports. All other signals travel
// through bus (ai_mem_arbiter_if.slave).
// Locked bursts keep the grant for up to MAX_BURST beats with no bubble. After that
// comes one IDLE cycle before the next arbitration.
module ai_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int XLEN      = 64,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            rst,
  ai_mem_arbiter_if.slave bus
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCW  = $clog2(MAX_BURST + 1);
  localparam int WCW  = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDXW-1:0]     last_q, last_d;
  logic [BCW-1:0]      beat_q, beat_d;
  logic [WCW-1:0]      wait_q, wait_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                tflag_q, tflag_d;

  logic [NUM_REQ-1:0]  req_eff;
  logic [IDXW-1:0]     gidx;
  logic [IDXW-1:0]     idx;
  logic [IDXW-1:0]     pick;
  logic                pick_vld;

  // A slot being told "done" this cycle still holds req_i, because it only sees the
  // pulse now. It must not be re-granted off that stale request.
  assign req_eff = bus.req_i & ~(ready_q | err_q);

  // Round-robin search upward from last_q+1. The first hit wins.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDXW'((int'(last_q) + i) % NUM_REQ);
      if (!pick_vld && req_eff[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Index of the one-hot grant, plus the downstream mux. It is all-zero while no grant is held.
  always_comb begin
    gidx          = '0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        gidx          = IDXW'(i);
        bus.mem_we    = bus.we_i[i];
        bus.mem_addr  = bus.addr_i[i*XLEN +: XLEN];
        bus.mem_wdata = bus.wdata_i[i*XLEN +: XLEN];
        bus.mem_wmask = bus.wmask_i[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    ready_d = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    tflag_d = tflag_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = NUM_REQ'(1) << pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Completion takes priority over both the request drop and the timeout.
        if (bus.mem_ready) begin
          ready_d = grant_q;
          rdata_d = bus.mem_rdata;
          wait_d  = '0;
          if (bus.lock_i[gidx] && (beat_q < BURST_LAST)) begin
            beat_d = beat_q + BCW'(1);
          end else begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = gidx;
            beat_d  = '0;
          end
        end else if (!bus.req_i[gidx]) begin
          // The requester withdrew. Abort silently.
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx;
          beat_d  = '0;
          wait_d  = '0;
        end else if (wait_q == WAIT_LIMIT) begin
          err_d   = grant_q;
          tflag_d = 1'b1;
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx;
          beat_d  = '0;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDXW'(NUM_REQ - 1);
      beat_q  <= '0;
      wait_q  <= '0;
      ready_q <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      tflag_q <= tflag_d;
    end
  end

  assign bus.mem_req      = (state_q == BUSY);
  assign bus.grant_o      = grant_q;
  assign bus.ready_o      = ready_q;
  assign bus.err_o        = err_q;
  assign bus.rdata_o      = rdata_q;
  assign bus.timeout_flag = tflag_q;
endmodule

// File: tb/tb_ai_mem_arbiter.sv
// Directed testbench for ai_mem_arbiter: reset, single grant, round-robin, burst lock,
// timeout, abort and asynchronous reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// The memory model returns mem_addr ^ RD_KEY as read data.
module tb_ai_mem_arbiter;
  localparam int NR = 4;
  localparam int XL = 64;
  localparam logic [XL-1:0] RD_KEY = 64'hA5A5_0000_5A5A_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ai_mem_arbiter_if #(.NUM_REQ(NR), .XLEN(XL)) bus ();

  ai_mem_arbiter #(.NUM_REQ(NR), .XLEN(XL), .MAX_BURST(16), .TIMEOUT(255)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = bus.mem_addr ^ RD_KEY;

  task automatic clear_inputs();
    bus.req_i     = '0;
    bus.lock_i    = '0;
    bus.we_i      = '0;
    bus.addr_i    = '0;
    bus.wdata_i   = '0;
    bus.wmask_i   = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req_i = 4'b1111;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.grant_o !== 4'b0 || bus.ready_o !== 4'b0 || bus.err_o !== 4'b0 ||
        bus.rdata_o !== 64'h0 || bus.timeout_flag !== 1'b0)
      begin fails++; $display("FAIL reset_req_side: grant=%b ready=%b err=%b rdata=%h tflag=%b, want all zero",
                     bus.grant_o, bus.ready_o, bus.err_o, bus.rdata_o, bus.timeout_flag); end
    tests++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 64'h0 ||
        bus.mem_wdata !== 64'h0 || bus.mem_wmask !== 8'h0)
      begin fails++; $display("FAIL reset_mem_side: req=%b we=%b addr=%h wdata=%h wmask=%h, want all zero",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask); end
  endtask

  task automatic test_single();
    do_reset();
    bus.addr_i[2*XL +: XL]  = 64'h1000;
    bus.wdata_i[2*XL +: XL] = 64'hDEAD_BEEF;
    bus.wmask_i[2*8 +: 8]   = 8'h0F;
    bus.mem_ready = 1'b1;
    bus.req_i[2]  = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.grant_o !== 4'b0100 || bus.mem_req !== 1'b1)
      begin fails++; $display("FAIL single_grant: grant=%b mem_req=%b, want 0100/1", bus.grant_o, bus.mem_req); end
    tests++;
    if (bus.mem_addr !== 64'h1000 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 64'hDEAD_BEEF ||
        bus.mem_wmask !== 8'h0F || bus.ready_o !== 4'b0)
      begin fails++; $display("FAIL single_mux: addr=%h we=%b wdata=%h wmask=%h ready=%b, want 1000/0/deadbeef/0f/0000",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wmask, bus.ready_o); end
    @(negedge clk);
    tests++;
    if (bus.ready_o !== 4'b0100 || bus.rdata_o !== (64'h1000 ^ RD_KEY))
      begin fails++; $display("FAIL single_ready: ready=%b rdata=%h, want 0100/%h",
                     bus.ready_o, bus.rdata_o, 64'h1000 ^ RD_KEY); end
    tests++;
    if (bus.grant_o !== 4'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== 64'h0)
      begin fails++; $display("FAIL single_idle: grant=%b mem_req=%b addr=%h, want 0/0/0",
                     bus.grant_o, bus.mem_req, bus.mem_addr); end
    // The requester still holds req here because it only just saw ready_o.
    @(negedge clk);
    tests++;
    if (bus.grant_o !== 4'b0 || bus.ready_o !== 4'b0)
      begin fails++; $display("FAIL single_no_regrant: grant=%b ready=%b, want 0000/0000", bus.grant_o, bus.ready_o); end
    bus.req_i = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g;
    logic [63:0] exp_a;
    int s;
    do_reset();
    for (int k = 0; k < NR; k++) bus.addr_i[k*XL +: XL] = 64'h2000 + 64'(k) * 64'h10;
    bus.mem_ready = 1'b1;
    bus.req_i     = 4'b1111;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      s     = (j / 2) % 4;
      exp_g = 4'b0001 << s;
      exp_a = 64'h2000 + 64'(s) * 64'h10;
      tests++;
      if ((j % 2) == 0) begin
        if (bus.grant_o !== exp_g || bus.mem_req !== 1'b1 || bus.mem_addr !== exp_a)
          begin fails++; $display("FAIL rr_grant step %0d: grant=%b mem_req=%b addr=%h, want %b/1/%h",
                         j, bus.grant_o, bus.mem_req, bus.mem_addr, exp_g, exp_a); end
      end else begin
        if (bus.grant_o !== 4'b0 || bus.mem_req !== 1'b0 || bus.ready_o !== exp_g)
          begin fails++; $display("FAIL rr_bubble step %0d: grant=%b mem_req=%b ready=%b, want 0000/0/%b",
                         j, bus.grant_o, bus.mem_req, bus.ready_o, exp_g); end
      end
    end
    bus.req_i = '0;
    @(negedge clk);
  endtask

  task automatic test_burst_lock();
    int run;
    int nrdy;
    do_reset();
    bus.addr_i[1*XL +: XL] = 64'h3000;
    bus.mem_ready = 1'b1;
    bus.req_i[1]  = 1'b1;
    bus.lock_i[1] = 1'b1;
    @(negedge clk);
    bus.req_i[0] = 1'b1;
    run  = 0;
    nrdy = 0;
    while (bus.grant_o === 4'b0010 && bus.mem_req === 1'b1 && run < 40) begin
      run++;
      @(negedge clk);
      if (bus.ready_o === 4'b0010) nrdy++;
    end
    tests++;
    if (run != 16)
      begin fails++; $display("FAIL burst_len: slot1 held %0d back-to-back cycles, want 16", run); end
    tests++;
    if (nrdy != 16)
      begin fails++; $display("FAIL burst_ready: %0d ready pulses, want 16", nrdy); end
    tests++;
    if (bus.grant_o !== 4'b0 || bus.mem_req !== 1'b0)
      begin fails++; $display("FAIL burst_bubble: grant=%b mem_req=%b, want 0000/0", bus.grant_o, bus.mem_req); end
    @(negedge clk);
    tests++;
    if (bus.grant_o !== 4'b0001 || bus.mem_req !== 1'b1)
      begin fails++; $display("FAIL burst_next: grant=%b mem_req=%b, want 0001/1", bus.grant_o, bus.mem_req); end
    bus.req_i  = '0;
    bus.lock_i = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int run;
    do_reset();
    bus.addr_i[3*XL +: XL] = 64'h4000;
    bus.mem_ready = 1'b0;
    bus.req_i[3]  = 1'b1;
    @(negedge clk);
    bus.req_i[0] = 1'b1;
    run = 0;
    while (bus.grant_o === 4'b1000 && run < 300) begin
      run++;
      @(negedge clk);
    end
    tests++;
    if (run != 256)
      begin fails++; $display("FAIL timeout_len: slot3 busy %0d cycles, want 256", run); end
    tests++;
    if (bus.err_o !== 4'b1000 || bus.timeout_flag !== 1'b1 || bus.ready_o !== 4'b0 || bus.mem_req !== 1'b0)
      begin fails++; $display("FAIL timeout_err: err=%b tflag=%b ready=%b mem_req=%b, want 1000/1/0000/0",
                     bus.err_o, bus.timeout_flag, bus.ready_o, bus.mem_req); end
    bus.req_i[3] = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.grant_o !== 4'b0001 || bus.err_o !== 4'b0)
      begin fails++; $display("FAIL timeout_next: grant=%b err=%b, want 0001/0000", bus.grant_o, bus.err_o); end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.req_i = '0;
    @(negedge clk);
    tests++;
    if (bus.timeout_flag !== 1'b1)
      begin fails++; $display("FAIL timeout_sticky: tflag=%b, want 1", bus.timeout_flag); end
  endtask

  task automatic test_abort_and_reset();
    do_reset();
    tests++;
    if (bus.timeout_flag !== 1'b0)
      begin fails++; $display("FAIL abort_flag_clear: tflag=%b, want 0", bus.timeout_flag); end
    bus.mem_ready = 1'b0;
    bus.req_i[0]  = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.grant_o !== 4'b0001)
      begin fails++; $display("FAIL abort_grant: grant=%b, want 0001", bus.grant_o); end
    repeat (2) @(negedge clk);
    bus.req_i[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.grant_o !== 4'b0 || bus.mem_req !== 1'b0 || bus.ready_o !== 4'b0 || bus.err_o !== 4'b0)
      begin fails++; $display("FAIL abort_idle: grant=%b mem_req=%b ready=%b err=%b, want 0/0/0/0",
                     bus.grant_o, bus.mem_req, bus.ready_o, bus.err_o); end
    @(negedge clk);
    tests++;
    if (bus.ready_o !== 4'b0 || bus.err_o !== 4'b0)
      begin fails++; $display("FAIL abort_no_pulse: ready=%b err=%b, want 0000/0000", bus.ready_o, bus.err_o); end
    // A request drop in the same cycle as mem_ready still completes the beat.
    bus.req_i[1] = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.grant_o !== 4'b0010)
      begin fails++; $display("FAIL drop_ready_grant: grant=%b, want 0010", bus.grant_o); end
    bus.req_i[1]  = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.ready_o !== 4'b0010 || bus.err_o !== 4'b0)
      begin fails++; $display("FAIL drop_ready_honoured: ready=%b err=%b, want 0010/0000", bus.ready_o, bus.err_o); end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.addr_i[2*XL +: XL] = 64'h5000;
    bus.req_i[2] = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.grant_o !== 4'b0100 || bus.mem_req !== 1'b1)
      begin fails++; $display("FAIL rst_pre_grant: grant=%b mem_req=%b, want 0100/1", bus.grant_o, bus.mem_req); end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (bus.grant_o !== 4'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== 64'h0)
      begin fails++; $display("FAIL rst_async: grant=%b mem_req=%b addr=%h, want 0/0/0",
                     bus.grant_o, bus.mem_req, bus.mem_addr); end
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_lock();
    test_timeout();
    test_abort_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ai_mem_arbiter.md
Name: ai_mem_arbiter

Overview:
- Arbitrates the single shared AI memory port between the AI execution units: matmul, conv2d, pooling and batchnorm.
- Each unit owns one requester slot.
- The arbiter grants one slot at a time using round-robin priority, holds the grant for a whole transaction or a locked burst, and bounds stalls with a timeout.
- It sits between the AI unit's compute engines and the memory interface of the AI instruction unit.

Parameters:
- NUM_REQ, 4, number of requester slots (slot 0 = matmul, 1 = conv2d, 2 = pooling, 3 = batchnorm).
- XLEN, 64, address and data width.
- MAX_BURST, 16, maximum consecutive beats a locked requester keeps the grant.
- TIMEOUT, 255, maximum wait cycles for mem_ready before the transaction is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-slot request; held high until ready_o or err_o for that slot.
- lock_i  in  NUM_REQ  per-slot burst lock; sampled on each completed beat.
- we_i  in  NUM_REQ  per-slot write enable.
- addr_i  in  NUM_REQ*XLEN  flattened addresses; slot k occupies bits [k*XLEN +: XLEN].
- wdata_i  in  NUM_REQ*XLEN  flattened write data.
- wmask_i  in  NUM_REQ*8  flattened byte masks.
- ready_o  out  NUM_REQ  one-cycle completion pulse to the granted slot.
- err_o  out  NUM_REQ  one-cycle timeout pulse to the granted slot.
- rdata_o  out  XLEN  read data, valid with the ready_o pulse.
- grant_o  out  NUM_REQ  one-hot current grant; zero when idle.
- mem_req  out  1  downstream request.
- mem_we  out  1  downstream write enable.
- mem_addr  out  XLEN  downstream address.
- mem_wdata  out  XLEN  downstream write data.
- mem_wmask  out  8  downstream byte mask.
- mem_rdata  in  XLEN  downstream read data.
- mem_ready  in  1  downstream completion.
- timeout_flag  out  1  sticky flag; cleared only by reset.

Behaviour:
- Reset values:
  - State IDLE; grant_o=0; mem_req=0.
  - mem_we, mem_addr, mem_wdata, mem_wmask = 0.
  - ready_o=0, err_o=0, rdata_o=0, timeout_flag=0.
  - last_grant = NUM_REQ-1, so slot 0 wins first.
  - beat_cnt=0, wait_cnt=0.
- While grant_o=0, all mem_* outputs are driven to 0.
- IDLE:
  - If any req_i is high, select the first requesting slot searching upward from last_grant+1 modulo NUM_REQ.
  - Register that slot into grant_o and go to BUSY.
  - Arbitration latency is 1 cycle: mem_req rises the cycle after req_i is seen.
- BUSY:
  - mem_req=1. mem_we, mem_addr, mem_wdata and mem_wmask are a combinational mux of the granted slot's inputs.
  - wait_cnt increments each cycle that mem_ready=0.
- Beat completion (BUSY and mem_ready=1):
  - Next cycle: ready_o[g]=1 for one cycle and rdata_o = registered mem_rdata.
  - wait_cnt clears.
  - beat_cnt increments.
- After a beat:
  - If lock_i[g]=1 and beat_cnt+1 < MAX_BURST, stay BUSY with the same grant. mem_req stays high with no bubble.
  - Otherwise go to IDLE, set last_grant=g and clear beat_cnt.
  - The IDLE cycle is the rearbitration bubble, so mem_req is low for exactly 1 cycle between different grants.
- Timeout: in BUSY with wait_cnt==TIMEOUT and mem_ready=0:
  - err_o[g] pulses for 1 cycle.
  - timeout_flag is set.
  - Go to IDLE with last_grant=g and counters cleared.
- Request drop: if req_i[g] falls while BUSY and mem_ready=0, abort to IDLE the next cycle. No ready_o or err_o pulse; last_grant=g.
- Simultaneous mem_ready and timeout: mem_ready wins and completes normally.
- Simultaneous mem_ready and req drop: the completion is honoured.
- Non-granted slots never see ready_o or err_o.
- A request arriving during BUSY waits; no preemption.
- Reset asserted mid-transaction: all outputs return to their reset values immediately (asynchronously); any in-flight beat is lost.

Test Plan:
- Single requester: slot 2 raises req with addr=0x1000, we=0; mem_ready held high → mem_req high 1 cycle after req, mem_addr=0x1000, ready_o=0b0100 with rdata_o=mem_rdata, then grant_o=0.
- Round-robin: all 4 slots request continuously without lock, mem_ready=1 → grant order 0,1,2,3,0, each separated by one idle cycle.
- Burst lock: slot 1 with lock=1 for 20 beats, slot 0 also requesting → slot 1 gets exactly 16 beats back-to-back, then one idle cycle, then slot 0 is granted.
- Timeout: grant slot 3, mem_ready=0 forever → err_o[3] pulses after 256 BUSY cycles, timeout_flag=1, and the next requester is granted.
- Abort and reset: slot 0 drops req mid-wait → no pulses, returns to IDLE. rst asserted during BUSY → mem_req=0 and grant_o=0 in the same cycle.
